// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the MEM stage: one load/store in flight at a time,
// a fixed number of wait states, and Stall held until the access completes.
module dmem_wait_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              MemR,
  input  logic              MemW,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              Ready,
  output logic              Stall,
  output logic              Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("dmem_wait_responder: WAIT_CYCLES must be in 1..15");
  end

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_data;
  logic              r_wr;
  logic [31:0]       r_mem [DEPTH];

  logic w_req;
  logic w_access;

  assign w_req    = MemR | MemW;
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

  // MemR and MemW together are latched as a store, so DataOut is left alone.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      DataOut <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr   <= DataAdr;
            r_data  <= DataIn;
            r_wr    <= MemW;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            if (!r_wr) begin
              DataOut <= r_mem[r_adr];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately unreset; a reset mid-WAIT forces IDLE so no write lands.
  always_ff @(posedge clk) begin
    if (w_access && r_wr) begin
      r_mem[r_adr] <= r_data;
    end
  end

  assign Ready = (r_state == S_DONE);
  assign Busy  = (r_state != S_IDLE);
  assign Stall = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=1 instance for the short-latency case.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        MemR0, MemW0, MemR1, MemW1;
  logic [7:0]  DataAdr;
  logic [31:0] DataIn;
  logic [31:0] DataOut0, DataOut1;
  logic        Ready0, Ready1, Stall0, Stall1, Busy0, Busy1;

  int total = 0;
  int bad   = 0;
  int cyc_abs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .Reset_n(Reset_n), .MemR(MemR0), .MemW(MemW0),
    .DataAdr(DataAdr), .DataIn(DataIn), .DataOut(DataOut0),
    .Ready(Ready0), .Stall(Stall0), .Busy(Busy0)
  );

  dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .Reset_n(Reset_n), .MemR(MemR1), .MemW(MemW1),
    .DataAdr(DataAdr), .DataIn(DataIn), .DataOut(DataOut1),
    .Ready(Ready1), .Stall(Stall1), .Busy(Busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending the DONE cycle.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [7:0] adr, input logic [31:0] din,
                        input bit chg, input logic [7:0] adr2, input logic [31:0] din2,
                        output logic [31:0] dout, output int stalls, output int rcyc,
                        output int rabs, output logic st_rdy);
    bit done;
    done   = 1'b0;
    stalls = 0;
    rcyc   = -1;
    rabs   = -1;
    dout   = 'x;
    st_rdy = 1'bx;
    DataAdr = adr;
    DataIn  = din;
    if (sel) begin MemR1 = rd; MemW1 = wr; end
    else     begin MemR0 = rd; MemW0 = wr; end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sel ? Ready1 : Ready0) begin
        done   = 1'b1;
        rcyc   = c;
        rabs   = cyc_abs;
        dout   = sel ? DataOut1 : DataOut0;
        st_rdy = sel ? Stall1 : Stall0;
      end else if (sel ? Stall1 : Stall0) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (c == 0 && chg) begin
        DataAdr = adr2;
        DataIn  = din2;
      end
    end
    MemR0 = 1'b0; MemW0 = 1'b0; MemR1 = 1'b0; MemW1 = 1'b0;
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] d;
  int          st, rc, ra, ra_first;
  logic        sr;

  initial begin
    Reset_n = 1'b0;
    MemR0 = 1'b0; MemW0 = 1'b0; MemR1 = 1'b0; MemW1 = 1'b0;
    DataAdr = '0; DataIn = '0;
    #1;
    chk("rst_dataout", DataOut0, 32'h0);
    chk("rst_busy",    {31'd0, Busy0},  32'd0);
    chk("rst_ready",   {31'd0, Ready0}, 32'd0);
    chk("rst_stall",   {31'd0, Stall0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) Reset_n = 1'b1;
    @(posedge clk); #1;

    // Store then load 0x05
    access(0, 0, 1, 8'h05, 32'hDEADBEEF, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("st05_stalls", st, 3);
    chk("st05_readycyc", rc, 3);
    chk("st05_stall_at_ready", {31'd0, sr}, 32'd0);
    access(0, 1, 0, 8'h05, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("ld05_data", d, 32'hDEADBEEF);
    chk("ld05_readycyc", rc, 3);

    // Back-to-back loads
    access(0, 0, 1, 8'h10, 32'h11111111, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    access(0, 0, 1, 8'h11, 32'h22222222, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    access(0, 1, 0, 8'h10, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("b2b_ld0_data", d, 32'h11111111);
    chk("b2b_ld0_stalls", st, 3);
    ra_first = ra;
    access(0, 1, 0, 8'h11, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("b2b_ld1_data", d, 32'h22222222);
    chk("b2b_ld1_stalls", st, 3);
    chk("b2b_ld1_stall_at_ready", {31'd0, sr}, 32'd0);
    chk("b2b_ready_spacing", ra - ra_first, 4);

    // Inputs changed during WAIT must be ignored
    access(0, 0, 1, 8'h21, 32'h5555AAAA, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    access(0, 0, 1, 8'h20, 32'hA5A5A5A5, 1, 8'h21, 32'h0, d, st, rc, ra, sr);
    access(0, 1, 0, 8'h20, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("chg_mem20", d, 32'hA5A5A5A5);
    access(0, 1, 0, 8'h21, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("chg_mem21", d, 32'h5555AAAA);

    // MemR and MemW together behave as a store
    access(0, 1, 1, 8'h30, 32'h12345678, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("both_dataout_held", d, 32'h5555AAAA);
    chk("both_readycyc", rc, 3);
    access(0, 1, 0, 8'h30, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("both_mem30", d, 32'h12345678);

    // Reset during WAIT aborts the store
    access(0, 0, 1, 8'h40, 32'h0BADC0DE, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    DataAdr = 8'h40; DataIn = 32'hCAFEF00D; MemW0 = 1'b1;
    @(posedge clk); #1;
    chk("rstw_busy_before", {31'd0, Busy0}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("rstw_busy", {31'd0, Busy0}, 32'd0);
    chk("rstw_dataout", DataOut0, 32'h0);
    chk("rstw_ready", {31'd0, Ready0}, 32'd0);
    chk("rstw_stall_idle_req", {31'd0, Stall0}, 32'd1);
    MemW0 = 1'b0;
    #1;
    chk("rstw_stall_idle_noreq", {31'd0, Stall0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) Reset_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 0, 8'h40, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("rstw_mem40_kept", d, 32'h0BADC0DE);

    // WAIT_CYCLES=1 instance, top address
    access(1, 0, 1, 8'hFF, 32'h0F0F1234, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("w1_st_stalls", st, 2);
    access(1, 1, 0, 8'hFF, 32'h0, 0, 8'h0, 32'h0, d, st, rc, ra, sr);
    chk("w1_ld_data", d, 32'h0F0F1234);
    chk("w1_ld_stalls", st, 2);
    chk("w1_ld_readycyc", rc, 2);
    chk("w1_ld_stall_at_ready", {31'd0, sr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Data-memory responder for the pipelined MIPS core's MEM stage. It accepts one load or store request at a time from the initiator side: MemR/MemW, word address, store data. It models a memory with a fixed number of wait states and asserts `Stall` so the core holds its pipeline until the access completes. It replaces the single-cycle data memory when the core runs against slower storage, and it returns load data on a registered output.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states per access. Legal range is 1..15; 0 is illegal.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `MemR`, input, 1: load request from MEM stage.
- `MemW`, input, 1: store request from MEM stage.
- `DataAdr`, input, ADDR_W: word address; the core drives ALU result bits [ADDR_W+1:2].
- `DataIn`, input, 32: store data.
- `DataOut`, output, 32: load data, registered.
- `Ready`, output, 1: one-cycle pulse when the access completes.
- `Stall`, output, 1: hold PC, IF/ID, ID/EX and EX/MEM while high.
- `Busy`, output, 1: responder is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - `req = MemR | MemW`.
  - If `req`: latch `DataAdr`, `DataIn` and op into internal registers, load `cnt = WAIT_CYCLES-1`, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Port inputs are ignored; only the latched copies are used.
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: perform the access at that edge and go to DONE.
    - Store: `mem[adr] <= data`.
    - Load: `DataOut <= mem[adr]`.
- DONE: `Ready = 1`, then go to IDLE unconditionally.
- `Stall = (state==IDLE & req) | (state==WAIT)`; combinational. `Stall` is 0 in DONE, so the pipeline advances on the DONE edge.
- `Busy = (state != IDLE)`.
- MemR and MemW both high: treated as a store. `DataOut` is unchanged.
- Back-to-back requests: a request present in the cycle after DONE is a new instruction and is accepted from IDLE normally. There is no bubble beyond the IDLE cycle.
- `DataOut` holds the last load result until the next load completes. Stores never modify `DataOut`.
- The memory array is not reset. Simulation content is loaded by `$readmemh` from the bench.

## Timing
- Request first seen in IDLE at cycle N:
  - `Stall` is high in cycles N .. N+WAIT_CYCLES (WAIT_CYCLES+1 cycles total).
  - `Ready` and `Stall=0` in cycle N+WAIT_CYCLES+1.
  - Load data is valid on `DataOut` from cycle N+WAIT_CYCLES+1 onward.
- A store is visible to a load accepted in a later IDLE cycle. There is no read-during-write hazard, because only one access is in flight.
- `Reset_n` low, asynchronous:
  - state = IDLE, `cnt` = 0, `DataOut` = 0, `Ready` = 0, `Busy` = 0.
  - `Stall` follows the IDLE equation immediately.
  - An in-flight access is aborted: no write occurs and `DataOut` stays 0.
- Reset deassertion is synchronised by the instantiating top; the block does not resynchronise it.
- The address wraps naturally at 2^ADDR_W. Upper address bits are never checked.

## Test plan
- Reset then store: release reset, then `MemW=1`, `DataAdr=0x05`, `DataIn=0xDEADBEEF` at cycle 0.
  - Required: `Stall` is 1 in cycles 0..2; `Ready` pulses in cycle 3.
  - Then a load from 0x05 returns `DataOut=0xDEADBEEF` in its DONE cycle.
- Back-to-back loads: words 0x10=0x11111111 and 0x11=0x22222222 preloaded; loads issued in consecutive accept cycles.
  - Required: two `Ready` pulses 4 cycles apart with `DataOut` 0x11111111 then 0x22222222.
  - `Stall` is low only in the DONE cycles.
- Input change during WAIT: accept a store to 0x20 with 0xA5A5A5A5, then change `DataAdr` to 0x21 and `DataIn` to 0 in cycle 1.
  - Required: mem[0x20]=0xA5A5A5A5; mem[0x21] unchanged.
- Simultaneous MemR and MemW to 0x30 with `DataIn=0x12345678`.
  - Required: mem[0x30]=0x12345678 and `DataOut` unchanged.
- Reset mid-WAIT: store to 0x40 with 0xCAFEF00D; pull `Reset_n` low in cycle 1.
  - Required: immediately `Busy=0` and `DataOut=0`, and mem[0x40] keeps its prior value.
- `WAIT_CYCLES=1` build with a load at address 0xFF.
  - Required: `Stall` is high for 2 cycles, and `Ready` is asserted in cycle 2 with the correct word.
